addsub_serial: RTL and testbench
================================

Name: addsub_serial

Overview:
- Parametrised, digit-serial adder/subtractor for two's-complement operands; successor to the fixed 4-bit combinational add/sub.
- Processes WIDTH-bit operands DIGIT bits per clock, reusing one DIGIT-wide ripple-carry slice.
- Valid/ready handshake on input and output; produces carry, signed overflow, zero and negative flags.
- Used wherever a wide add/sub is needed and area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH. NDIG = WIDTH/DIGIT.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- x  in  WIDTH  first operand.
- y  in  WIDTH  second operand.
- sub  in  1  0 = x+y, 1 = x-y.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  result.
- cout  out  1  carry out of MSB; for sub, 1 = no borrow (x >= y unsigned).
- ovf  out  1  signed overflow.
- zero  out  1  s == 0.
- neg  out  1  s[WIDTH-1].

Behaviour:
- Interface timing:
  - One clock domain (clk).
  - rst_n is asynchronous and active-low.
- Reset values:
  - State goes to IDLE.
  - s, cout, ovf, zero, neg and out_valid all reset to 0.
  - in_ready = (state == IDLE), so it reads 1 during and after reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: capture opA = x, opB = y XOR {WIDTH{sub}}, carry = sub, digit counter = 0; go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle: add opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry.
  - Shift the DIGIT-bit sum into s from the MSB end (right shift). Shift opA and opB right by DIGIT. Update carry. Increment counter.
  - On the cycle where counter == NDIG-1:
    - Record carry-out as cout.
    - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
    - Go to DONE.
- DONE:
  - out_valid = 1; zero and neg reflect the final s.
  - s and all flags held stable while out_valid && !out_ready.
  - On out_ready: out_valid drops next edge; go to IDLE.
- Latency:
  - Operands accepted on edge E0; out_valid is high after edge E0+NDIG.
  - Minimum 1 idle cycle between result handshake and the next accept; no overlap of operations.
- Operand isolation: x, y and sub are ignored outside the accepting edge; changes during RUN/DONE have no effect.
- DIGIT == WIDTH is legal: one RUN cycle, out_valid after E0+1.
- Arithmetic: modulo 2^WIDTH (wrap) unless the optional feature is enabled.
- Flag retention: flags and s retain the last result after the handshake until the next DONE entry. out_valid is the only qualifier.
- Reset mid-operation: any state aborts to IDLE with all outputs cleared; the aborted result is never presented.
- in_valid asserted during RUN/DONE: not accepted; in_ready stays 0.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined (saturating mode):
  - When ovf = 1 at DONE entry, s is clamped.
  - Positive overflow (result sign 1, operand sign bits 0) → 2^(WIDTH-1)-1.
  - Negative overflow → -2^(WIDTH-1).
  - ovf still reports 1; cout is unaffected; zero and neg are computed on the clamped s.
  - Latency unchanged.
- Not defined: wrapping result, no clamp logic present.

Test Plan:
- WIDTH=16, DIGIT=4: 0x1234 + 0x0FFF, sub=0 → s=0x2233, cout=0, ovf=0, zero=0, neg=0; out_valid after 4th edge post-accept.
- 0x0005 - 0x0007, sub=1 → s=0xFFFE, cout=0, ovf=0, neg=1. Then 0x1234 - 0x1234 → s=0x0000, zero=1, cout=1.
- 0x7FFF + 0x0001 → s=0x8000, ovf=1, neg=1, cout=0 (with ADDSUB_SAT_EN: s=0x7FFF, neg=0). 0x8000 - 0x0001 → s=0x7FFF, ovf=1, cout=1 (SAT: s=0x8000).
- Backpressure: hold out_ready=0 for 3 cycles and pulse in_valid with new operands → s/flags stable, in_ready=0, new operands not taken. out_ready=1 → in_ready=1 on the next cycle.
- Reset: drop rst_n during the 2nd RUN cycle → all outputs 0 immediately, in_ready=1; after release no out_valid until a new accept.
- Parameter sweep: DIGIT=1, 8, 16 with WIDTH=16 on random vectors → results match a reference model; latency = NDIG edges.

Source files
------------

// File: rtl/addsub_serial_if.sv
// Operand/result handshake bundle for the digit-serial adder/subtractor.
// The master side drives operands and result acceptance. The slave side (the datapath) returns the result and flags.
interface addsub_serial_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, x, y, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, x, y, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero, neg
  );
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement add/sub: one DIGIT-wide ripple slice is reused NDIG times per operation.
// Optional macro ADDSUB_SAT_EN clamps an overflowing result to the signed min/max.
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic            clk,
  input logic            rst_n,
  addsub_serial_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               out_valid_q, out_valid_d;

  logic [DIGIT:0]       slice_s;
  logic [WIDTH+DIGIT-1:0] acc_wide_s;
  logic [WIDTH-1:0]     acc_next_s;
  logic [WIDTH-1:0]     res_s;
  logic                 ovf_s;

  // Shared ripple slice. The partial result fills acc from the MSB end, so s stays untouched until DONE entry.
  always_comb begin
    slice_s    = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    acc_wide_s = {slice_s[DIGIT-1:0], acc_q} >> DIGIT;
    acc_next_s = acc_wide_s[WIDTH-1:0];
    // carry into the slice MSB is recovered as a^b^sum at that bit
    ovf_s      = opa_q[DIGIT-1] ^ opb_q[DIGIT-1] ^ slice_s[DIGIT-1] ^ slice_s[DIGIT];
`ifdef ADDSUB_SAT_EN
    if (ovf_s) begin
      res_s = {~acc_next_s[WIDTH-1], {(WIDTH-1){acc_next_s[WIDTH-1]}}};
    end else begin
      res_s = acc_next_s;
    end
`else
    res_s = acc_next_s;
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          opa_d   = bus.x;
          opb_d   = bus.y ^ {WIDTH{bus.sub}};
          carry_d = bus.sub;
          cnt_d   = {CW{1'b0}};
          acc_d   = {WIDTH{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d   = acc_next_s;
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        carry_d = slice_s[DIGIT];
        cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(NDIG - 1)) begin
          s_d         = res_s;
          cout_d      = slice_s[DIGIT];
          ovf_d       = ovf_s;
          zero_d      = (res_s == {WIDTH{1'b0}});
          neg_d       = res_s[WIDTH-1];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      opa_q       <= {WIDTH{1'b0}};
      opb_q       <= {WIDTH{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      s_q         <= {WIDTH{1'b0}};
      cnt_q       <= {CW{1'b0}};
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: WIDTH=16 with DIGIT=4 (main), 1, 8 and 16 instances side by side.
// Expected values are hand-computed; ADDSUB_SAT_EN selects the clamped expectations.
module tb_addsub_serial;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] x_r, y_r;
  logic        sub_r;
  logic        in_valid_r [4];
  logic        out_ready_r [4];
  logic        ir_w [4];
  logic        ov_w [4];
  logic        cout_w [4];
  logic        ovf_w [4];
  logic        zero_w [4];
  logic        neg_w [4];
  logic [15:0] s_w [4];
  int          n_err = 0;
  int          n_chk = 0;
  string       cur = "reset";

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      localparam int DG = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 16;
      addsub_serial_if #(.WIDTH(16)) bus ();
      assign bus.in_valid  = in_valid_r[g];
      assign bus.out_ready = out_ready_r[g];
      assign bus.x         = x_r;
      assign bus.y         = y_r;
      assign bus.sub       = sub_r;
      assign ir_w[g]       = bus.in_ready;
      assign ov_w[g]       = bus.out_valid;
      assign s_w[g]        = bus.s;
      assign cout_w[g]     = bus.cout;
      assign ovf_w[g]      = bus.ovf;
      assign zero_w[g]     = bus.zero;
      assign neg_w[g]      = bus.neg;
      addsub_serial #(.WIDTH(16), .DIGIT(DG)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0h expected %0h", cur, tag, got, exp);
    end
  endtask

  task automatic check_res(input int k, input logic [15:0] es, input logic ec, input logic eo,
                           input logic ez, input logic en);
    check("s", {16'd0, s_w[k]}, {16'd0, es});
    check("cout", {31'd0, cout_w[k]}, {31'd0, ec});
    check("ovf", {31'd0, ovf_w[k]}, {31'd0, eo});
    check("zero", {31'd0, zero_w[k]}, {31'd0, ez});
    check("neg", {31'd0, neg_w[k]}, {31'd0, en});
  endtask

  // Accept on instance k, scramble operands during RUN, time out_valid, check, then handshake.
  task automatic do_op(input string name, input int k, input logic [15:0] a, input logic [15:0] b,
                       input logic sb, input logic [15:0] es, input logic ec, input logic eo,
                       input logic ez, input logic en, input int elat);
    int lat;
    cur = name;
    @(negedge clk);
    x_r = a; y_r = b; sub_r = sb; in_valid_r[k] = 1'b1;
    check("in_ready", {31'd0, ir_w[k]}, 32'd1);
    @(posedge clk); #1;
    in_valid_r[k] = 1'b0; x_r = 16'hDEAD; y_r = 16'hBEEF; sub_r = ~sb;
    lat = 0;
    while (ov_w[k] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, elat);
    check_res(k, es, ec, eo, ez, en);
    out_ready_r[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_r[k] = 1'b0;
    check("valid_drop", {31'd0, ov_w[k]}, 32'd0);
    check("ready_back", {31'd0, ir_w[k]}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sat_p, sat_n;
    logic        seen;
`ifdef ADDSUB_SAT_EN
    sat_p = 16'h7FFF; sat_n = 16'h8000;
`else
    sat_p = 16'h8000; sat_n = 16'h7FFF;
`endif
    rst_n = 1'b0; x_r = 16'h0000; y_r = 16'h0000; sub_r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid_r[i] = 1'b0;
      out_ready_r[i] = 1'b0;
    end
    #12;
    check("in_ready", {31'd0, ir_w[0]}, 32'd1);
    check("out_valid", {31'd0, ov_w[0]}, 32'd0);
    check_res(0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    do_op("add", 0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    do_op("sub_neg", 0, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    do_op("sub_zero", 0, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4);
    do_op("ovf_pos", 0, 16'h7FFF, 16'h0001, 1'b0, sat_p, 1'b0, 1'b1, 1'b0, sat_p[15], 4);
    do_op("ovf_neg", 0, 16'h8000, 16'h0001, 1'b1, sat_n, 1'b1, 1'b1, 1'b0, sat_n[15], 4);

    // Backpressure: result held while out_ready is low and new operands are offered.
    cur = "bp";
    @(negedge clk);
    x_r = 16'h0001; y_r = 16'h0002; sub_r = 1'b0; in_valid_r[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_r[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("valid", {31'd0, ov_w[0]}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      x_r = 16'hAAAA; y_r = 16'h5555; in_valid_r[0] = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", {31'd0, ov_w[0]}, 32'd1);
      check("hold_ready", {31'd0, ir_w[0]}, 32'd0);
      check("hold_s", {16'd0, s_w[0]}, 32'h0003);
    end
    @(negedge clk);
    in_valid_r[0] = 1'b0; out_ready_r[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_r[0] = 1'b0;
    check("rel_valid", {31'd0, ov_w[0]}, 32'd0);
    check("rel_ready", {31'd0, ir_w[0]}, 32'd1);
    check("retain_s", {16'd0, s_w[0]}, 32'h0003);

    // Reset in the second RUN cycle aborts the operation.
    cur = "rst_mid";
    @(negedge clk);
    x_r = 16'h1234; y_r = 16'h0FFF; sub_r = 1'b0; in_valid_r[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_r[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("ready", {31'd0, ir_w[0]}, 32'd1);
    check("valid", {31'd0, ov_w[0]}, 32'd0);
    check_res(0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      seen = seen | ov_w[0];
    end
    check("no_stale_valid", {31'd0, seen}, 32'd0);
    do_op("after_rst", 0, 16'h0100, 16'h0023, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b0, 1'b0, 4);

    // Digit-width sweep: DIGIT = 1, 8, 16 on instances 1..3.
    for (int k = 1; k < 4; k++) begin
      int el;
      el = (k == 1) ? 16 : (k == 2) ? 2 : 1;
      do_op("sw_add", k, 16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0, 1'b0, 1'b1, el);
      do_op("sw_ovf", k, 16'h4000, 16'hC000, 1'b1, sat_p, 1'b0, 1'b1, 1'b0, sat_p[15], el);
      do_op("sw_wrap", k, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, el);
      do_op("sw_min", k, 16'h9000, 16'h1000, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, el);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
